// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, frame constants and
// a 3-input majority helper used by the optional sample filter.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_WAITHI = 3'd4;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StStop   = ST_STOP,
    StWaitHi = ST_WAITHI
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial receive bundle: raw line in, decoded byte stream out.
//   rx_pin       : raw serial line, idle high
//   rx_data      : last good byte
//   rx_avail     : one-cycle strobe, rx_data valid in the same cycle
//   rx_frame_err : one-cycle strobe on a low stop bit
// slave  = receiver side, master = line driver / byte consumer side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_pin;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_avail;
  logic                 rx_frame_err;

  modport slave (
    input  rx_pin,
    output rx_data,
    output rx_avail,
    output rx_frame_err
  );

  modport master (
    output rx_pin,
    input  rx_data,
    input  rx_avail,
    input  rx_frame_err
  );

endinterface

// File: rtl/uart_rx_filter.sv
// RX line conditioning: 2-flop synchroniser plus optional majority filter.
// Macro UART_RX_MAJORITY_EN: when defined, bit_val is the majority of rx_s
// over the current and two preceding edges; otherwise bit_val = rx_s.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   rx_pin   : raw asynchronous serial line
//   rx_s     : synchronised line (used for start detection)
//   bit_val  : value used at sample points
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  output logic rx_s,
  output logic bit_val
);

  logic sync1_q;
  logic sync2_q;

  // Both flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one edge ago, hist_q[1] two edges ago.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
    end
  end

  assign bit_val = majority3(sync2_q, hist_q[0], hist_q[1]);
`else
  assign bit_val = sync2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, fixed CLK_DIV clocks per bit (even, >= 4).
// Good bytes appear as a one-cycle rx_avail strobe with no backpressure;
// a low stop bit gives one rx_frame_err strobe and the byte is dropped.
// Optional majority sampling is selected by UART_RX_MAJORITY_EN inside
// uart_rx_filter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   rx_if    : uart_rx_if.slave (rx_pin in; rx_data, rx_avail, rx_frame_err out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_if.slave     rx_if
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  logic rx_s;
  logic bit_val;

  uart_rx_filter u_filter (
    .clk     (clk),
    .rst     (rst),
    .rx_pin  (rx_if.rx_pin),
    .rx_s    (rx_s),
    .bit_val (bit_val)
  );

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 avail_q, avail_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    avail_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Start detection uses the raw synchronised line, never the filter.
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end

      StStart: begin
        if (cnt_q == '0) begin
          if (!bit_val) begin
            state_d = StData;
            cnt_d   = CntFull;
            idx_d   = '0;
          end else begin
            state_d = StIdle;  // start bit did not hold to mid-bit: glitch
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == '0) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          cnt_d   = CntFull;
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == '0) begin
          // Back to IDLE at mid stop bit so a following start edge is not missed.
          if (bit_val) begin
            data_d  = shift_q;
            avail_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHi;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StWaitHi: begin
        // Swallow a line break until the line returns high.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_if.rx_data      = data_q;
  assign rx_if.rx_avail     = avail_q;
  assign rx_if.rx_frame_err = err_q;

endmodule
